// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and multiply/divide sequencer.
// ALUOp values, funct fields, ALU control codes and sequencer states.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  localparam logic [3:0] G_AND  = 4'b0000;
  localparam logic [3:0] G_OR   = 4'b0001;
  localparam logic [3:0] G_ADD  = 4'b0010;
  localparam logic [3:0] G_SRL  = 4'b0100;
  localparam logic [3:0] G_SLL  = 4'b0101;
  localparam logic [3:0] G_SUB  = 4'b0110;
  localparam logic [3:0] G_SLT  = 4'b0111;
  localparam logic [3:0] G_PASS = 4'b1000;
  localparam logic [3:0] G_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_control_md_decode.sv
// Combinational aluop/funct decoder: ALU control code, illegal flag,
// and the HI/LO instruction classes used by the sequencer.
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic              valid_in,
  input  logic [2:0]        aluop,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] gout,
  output logic              illegal,
  output logic              is_md,
  output logic              is_hl
);

  logic [3:0] w_code;
  logic       w_illegal;
  logic       w_rtype;

  always_comb begin
    w_code    = G_ADD;
    w_illegal = 1'b0;
    unique case (aluop)
      OP_SUB: w_code = G_SUB;
      OP_AND: w_code = G_AND;
      OP_OR:  w_code = G_OR;
      OP_SLT: w_code = G_SLT;
      OP_RTYPE: begin
        unique case (funct)
          F_ADD:  w_code = G_ADD;
          F_SUB:  w_code = G_SUB;
          F_AND:  w_code = G_AND;
          F_OR:   w_code = G_OR;
          F_NOR:  w_code = G_NOR;
          F_SLT:  w_code = G_SLT;
          F_SLL:  w_code = G_SLL;
          F_SRL:  w_code = G_SRL;
          F_MULT, F_DIV,
          F_MFHI, F_MFLO: w_code = G_PASS;
          default: w_illegal = 1'b1;
        endcase
      end
      // lw/sw and the reserved 110/111 encodings all add
      default: w_code = G_ADD;
    endcase
  end

  assign w_rtype = valid_in & (aluop == OP_RTYPE);
  assign gout    = CTRL_W'(w_code);
  assign illegal = w_illegal;
  assign is_md   = w_rtype & ((funct == F_MULT) | (funct == F_DIV));
  assign is_hl   = w_rtype & ((funct == F_MFHI) | (funct == F_MFLO));

endmodule

// File: rtl/alu_control_md.sv
// ALU control decoder plus multi-cycle multiply/divide sequencer:
// launches the HI/LO unit, counts its latency and stalls dependents.
module alu_control_md
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [2:0]        aluop,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] gout,
  output logic              illegal,
  output logic              md_start,
  output logic              md_op,
  output logic              stall,
  output logic              hilo_we,
  output logic              md_done
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        r_state;
  md_state_e        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_start;
  logic             r_md_op;
  logic             r_hilo_we;
  logic             w_is_md;
  logic             w_is_hl;
  logic             w_accept;
  logic             w_last;

  alu_funct_decode #(
    .CTRL_W(CTRL_W)
  ) u_dec (
    .valid_in(valid_in),
    .aluop   (aluop),
    .funct   (funct),
    .gout    (gout),
    .illegal (illegal),
    .is_md   (w_is_md),
    .is_hl   (w_is_hl)
  );

  assign w_last = (r_state == S_BUSY) & (r_cnt == '0);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_is_md) begin
          w_accept = 1'b1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_md_start <= 1'b0;
      r_md_op    <= 1'b0;
      r_hilo_we  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_md_start <= w_accept;
      r_hilo_we  <= w_last;
      if (w_accept) begin
        r_md_op <= funct[1];
        r_cnt   <= funct[1] ? DIV_LD : MUL_LD;
      end else if (r_state == S_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // mult/div or mfhi/mflo must wait for the whole BUSY..DONE window
  assign stall    = (w_is_md | w_is_hl) & (r_state != S_IDLE);
  assign md_start = r_md_start;
  assign md_op    = r_md_op;
  assign hilo_we  = r_hilo_we;
  assign md_done  = r_hilo_we;

endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: a timeline model of the HI/LO unit checked
// every cycle on two builds, plus directed vectors with literal results.
module tb_alu_control_md;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [2:0] aluop;
  logic [5:0] funct;

  logic [3:0] gout0, gout1;
  logic       ill0, ill1, st0, st1, op0, op1;
  logic       stl0, stl1, we0, we1, dn0, dn1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_control_md dut0 (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .aluop(aluop), .funct(funct), .gout(gout0),
    .illegal(ill0), .md_start(st0), .md_op(op0),
    .stall(stl0), .hilo_we(we0), .md_done(dn0)
  );

  alu_control_md #(.MUL_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .aluop(aluop), .funct(funct), .gout(gout1),
    .illegal(ill1), .md_start(st1), .md_op(op1),
    .stall(stl1), .hilo_we(we1), .md_done(dn1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // decode reference: {illegal, gout}
  function automatic logic [4:0] m_dec(input logic [2:0] op,
                                       input logic [5:0] f);
    if (op == 3'd1) return 5'b0_0110;
    if (op == 3'd3) return 5'b0_0000;
    if (op == 3'd4) return 5'b0_0001;
    if (op == 3'd5) return 5'b0_0111;
    if (op != 3'd2) return 5'b0_0010;
    case (f)
      6'd32: return 5'b0_0010;
      6'd34: return 5'b0_0110;
      6'd36: return 5'b0_0000;
      6'd37: return 5'b0_0001;
      6'd39: return 5'b0_1100;
      6'd42: return 5'b0_0111;
      6'd0:  return 5'b0_0101;
      6'd2:  return 5'b0_0100;
      6'd24, 6'd26, 6'd16, 6'd18: return 5'b0_1000;
      default: return 5'b1_0010;
    endcase
  endfunction

  // timeline model: each accepted op occupies cycles [start, done]
  int cyc = 0;
  int m_st [2];
  int m_dn [2];
  bit m_op [2];
  int mul_lat [2] = '{4, 1};

  function automatic bit m_is_md();
    return valid_in && aluop == 3'd2 && (funct == 6'd24 || funct == 6'd26);
  endfunction

  function automatic bit m_is_hl();
    return valid_in && aluop == 3'd2 && (funct == 6'd16 || funct == 6'd18);
  endfunction

  function automatic bit m_busy(input int i);
    return m_st[i] >= 0 && cyc >= m_st[i] && cyc <= m_dn[i];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_st[i] <= -1;
        m_dn[i] <= -1;
        m_op[i] <= 1'b0;
      end else if (m_is_md() && !m_busy(i)) begin
        m_st[i] <= cyc + 1;
        m_dn[i] <= cyc + 1 + (funct[1] ? 32 : mul_lat[i]);
        m_op[i] <= funct[1];
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] d;
    bit s;
    d = m_dec(aluop, funct);
    for (int i = 0; i < 2; i++) begin
      s = (m_is_md() || m_is_hl()) && m_busy(i);
      chk($sformatf("m%0d.gout", i), int'(i ? gout1 : gout0), int'(d[3:0]));
      chk($sformatf("m%0d.illegal", i), int'(i ? ill1 : ill0), int'(d[4]));
      chk($sformatf("m%0d.stall", i), int'(i ? stl1 : stl0), int'(s));
      chk($sformatf("m%0d.md_start", i), int'(i ? st1 : st0),
          int'(cyc == m_st[i]));
      chk($sformatf("m%0d.hilo_we", i), int'(i ? we1 : we0),
          int'(cyc == m_dn[i]));
      chk($sformatf("m%0d.md_done", i), int'(i ? dn1 : dn0),
          int'(cyc == m_dn[i]));
      chk($sformatf("m%0d.md_op", i), int'(i ? op1 : op0), int'(m_op[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [2:0] op,
                     input logic [5:0] f);
    valid_in = v;
    aluop    = op;
    funct    = f;
  endtask

  task automatic idle(input int n);
    put(1'b0, 3'd0, 6'd0);
    repeat (n) tick();
  endtask

  logic [3:0] sweep_exp [8] = '{4'h2, 4'h6, 4'h5, 4'h0,
                                4'h1, 4'h7, 4'h2, 4'h2};
  logic [5:0] r_fn  [12] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42,
                             6'd0, 6'd2, 6'd24, 6'd26, 6'd16, 6'd18};
  logic [3:0] r_gx  [12] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hC, 4'h7,
                             4'h5, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    put(1'b0, 3'd0, 6'd0);
    #3;
    chk("rst.md_start", int'(st0), 0);
    chk("rst.hilo_we", int'(we0), 0);
    chk("rst.md_op", int'(op0), 0);
    chk("rst.stall", int'(stl0), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // decode sweep
    for (int a = 0; a < 8; a++) begin
      put(1'b0, 3'(a), 6'd0);
      #1 chk($sformatf("sweep.op%0d", a), int'(gout0), int'(sweep_exp[a]));
      chk($sformatf("sweep.ill%0d", a), int'(ill0), 0);
    end
    for (int k = 0; k < 12; k++) begin
      put(1'b0, 3'd2, r_fn[k]);
      #1 chk($sformatf("rtype.f%0d", r_fn[k]), int'(gout0), int'(r_gx[k]));
      chk($sformatf("rtype.ill%0d", r_fn[k]), int'(ill0), 0);
    end
    put(1'b0, 3'd2, 6'h3f);
    #1 chk("bad.gout", int'(gout0), 2);
    chk("bad.ill", int'(ill0), 1);
    put(1'b0, 3'd0, 6'h3f);
    #1 chk("bad.ill.op0", int'(ill0), 0);
    idle(2);

    // mult with default latency, and the MUL_CYCLES=1 build alongside
    put(1'b1, 3'd2, 6'd24);
    tick();
    put(1'b0, 3'd0, 6'd0);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("mul.start@%0d", k), int'(st0), int'(k == 1));
      chk($sformatf("mul.we@%0d", k), int'(we0), int'(k == 5));
      chk($sformatf("mul.done@%0d", k), int'(dn0), int'(k == 5));
      chk($sformatf("mul.op@%0d", k), int'(op0), 0);
      chk($sformatf("mul1.start@%0d", k), int'(st1), int'(k == 1));
      chk($sformatf("mul1.we@%0d", k), int'(we1), int'(k == 2));
      tick();
    end
    idle(2);

    // div then a dependent mflo held in execute
    put(1'b1, 3'd2, 6'd26);
    tick();
    put(1'b1, 3'd2, 6'd18);
    for (int k = 1; k <= 34; k++) begin
      chk($sformatf("div.stall@%0d", k), int'(stl0), int'(k <= 33));
      chk($sformatf("div.we@%0d", k), int'(we0), int'(k == 33));
      if (k < 34) tick();
    end
    idle(2);

    // back-to-back mult then div
    put(1'b1, 3'd2, 6'd24);
    tick();
    put(1'b1, 3'd2, 6'd26);
    for (int k = 1; k <= 40; k++) begin
      if (k <= 6)
        chk($sformatf("b2b.stall@%0d", k), int'(stl0), int'(k <= 5));
      chk($sformatf("b2b.start@%0d", k), int'(st0),
          int'(k == 1 || k == 7));
      chk($sformatf("b2b.we@%0d", k), int'(we0), int'(k == 5 || k == 39));
      if (k >= 7) chk($sformatf("b2b.op@%0d", k), int'(op0), 1);
      tick();
      if (k == 6) put(1'b0, 3'd0, 6'd0);
    end
    idle(2);

    // unrelated instructions flow freely while busy
    put(1'b1, 3'd2, 6'd24);
    tick();
    for (int k = 1; k <= 6; k++) begin
      case (k % 3)
        0: put(1'b1, 3'd2, 6'd32);
        1: put(1'b1, 3'd2, 6'd34);
        default: put(1'b1, 3'd0, 6'd26);
      endcase
      #1 chk($sformatf("free.stall@%0d", k), int'(stl0), 0);
      chk($sformatf("free.gout@%0d", k), int'(gout0),
          (k % 3 == 1) ? 6 : 2);
      tick();
    end
    idle(2);

    // reset in the middle of a divide
    put(1'b1, 3'd2, 6'd26);
    tick();
    put(1'b0, 3'd0, 6'd0);
    repeat (9) tick();
    chk("abort.pre_start", int'(st0), 0);
    #1 reset = 1'b1;
    #1 chk("abort.start", int'(st0), 0);
    chk("abort.we", int'(we0), 0);
    chk("abort.done", int'(dn0), 0);
    put(1'b1, 3'd2, 6'd18);
    #1 chk("abort.stall", int'(stl0), 0);
    put(1'b0, 3'd0, 6'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("abort.nowe@%0d", k), int'(we0 | we1), 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
